// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  // Read-return tracking: which requester owns the data arriving next cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_C = 2'd1,
    ST_RD_D = 2'd2
  } rd_state_e;

  // Requester that owns the memory port this cycle
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_C    = 2'd1,
    WIN_D    = 2'd2
  } winner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and memory-macro signals around the arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // core load/store unit
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W/8-1:0] c_be;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_kill;

  // debug / memory-dump port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // single-port synchronous memory macro
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0] m_rdata;

  // arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be, c_kill,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  // requesters and memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be, c_kill,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-port data memory. Core has priority,
// a starvation counter forces a debug grant, read data returns one cycle
// after accept and a core read can be cancelled by a flush (c_kill).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RD_C = ST_RD_C;
  localparam logic [1:0] S_RD_D = ST_RD_D;

  logic [CNT_W-1:0] starve_cnt;
  logic             force_d;
  winner_e          winner;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  assign force_d = (starve_cnt == CNT_LIMIT);

  // Pick the requester for this cycle; nothing is granted while in reset
  always_comb begin
    winner = WIN_NONE;
    if (rst_n) begin
      if (bus.d_req && force_d) winner = WIN_D;
      else if (bus.c_req)       winner = WIN_C;
      else if (bus.d_req)       winner = WIN_D;
    end
  end

  assign bus.c_gnt = (winner == WIN_C);
  assign bus.d_gnt = (winner == WIN_D);

  // Steer the winner's access onto the memory port; idle port drives zeros
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_be    = '0;
    case (winner)
      WIN_C: begin
        bus.m_en    = 1'b1;
        bus.m_we    = bus.c_we;
        bus.m_addr  = bus.c_addr;
        bus.m_wdata = bus.c_wdata;
        bus.m_be    = bus.c_we ? bus.c_be : '0;
      end
      WIN_D: begin
        bus.m_en    = 1'b1;
        bus.m_we    = bus.d_we;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
        bus.m_be    = bus.d_we ? bus.d_be : '0;
      end
      default: ;
    endcase
  end

  // Count consecutive cycles the debug port waits; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.d_req || bus.d_gnt) begin
      starve_cnt <= '0;
    end else if (!force_d) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Remember which requester's read data arrives next cycle
  always_comb begin
    state_nxt = S_IDLE;
    if (winner == WIN_C && !bus.c_we)      state_nxt = S_RD_C;
    else if (winner == WIN_D && !bus.d_we) state_nxt = S_RD_D;
  end

  // Read-return state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A flush in the return cycle cancels the core read now coming back
  assign bus.c_rvalid = (state == S_RD_C) && !bus.c_kill;
  assign bus.d_rvalid = (state == S_RD_D);
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

endmodule
